iter_multiplier: RTL and testbench



---
 rtl/iter_multiplier_if.sv | 53 +++++
 rtl/iter_multiplier.sv | 138 +++++++++++++
 tb/tb_iter_multiplier.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/iter_multiplier_if.sv
// Handshake bundle for iter_multiplier.
//   master: the producer/consumer side (drives operands, modes and out_ready).
//   slave : the multiplier side (drives in_ready, busy, out_valid, product).
// Signals:
//   in_valid / in_ready   operand handshake
//   a, b                  multiplicand / multiplier, WIDTH bits
//   signed_a, signed_b    two's-complement interpretation of a / b
//   busy                  unit is not idle
//   out_valid / out_ready product handshake
//   product               2*WIDTH-bit registered result
// WIDTH must match the WIDTH of the iter_multiplier it is connected to.
interface iter_multiplier_if #(
  parameter int unsigned WIDTH = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   signed_a;
  logic                   signed_b;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output in_valid,
    output a,
    output b,
    output signed_a,
    output signed_b,
    output out_ready,
    input  in_ready,
    input  busy,
    input  out_valid,
    input  product
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  signed_a,
    input  signed_b,
    input  out_ready,
    output in_ready,
    output busy,
    output out_valid,
    output product
  );

endinterface

// File: rtl/iter_multiplier.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH integer multiplier with valid/ready on both sides.
// Operands are converted to sign + magnitude on accept; the magnitudes are multiplied
// STEP multiplier bits per cycle (N = WIDTH/STEP cycles) and the sign is applied on the
// final iteration. A zero operand skips the iterations and completes on the accept edge.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset, discards any in-flight operation
//   bus  - iter_multiplier_if slave modport (operand/product handshakes, busy)
// Constraints: WIDTH even and >= 4, WIDTH % STEP == 0.
module iter_multiplier #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 2
) (
  input logic                clk,
  input logic                rst,
  iter_multiplier_if.slave   bus
);

  localparam int unsigned N    = WIDTH / STEP;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ShW  = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 neg_a;
  logic                 neg_b;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   pp_shift;
  logic [2*WIDTH-1:0]   acc_next;
  logic [ShW-1:0]       shamt;

  assign neg_a = bus.signed_a & bus.a[WIDTH-1];
  assign neg_b = bus.signed_b & bus.b[WIDTH-1];

  // One radix-2^STEP digit of the multiplier times the full multiplicand, placed at the
  // digit's weight. The sum of all digits never exceeds 2*WIDTH bits.
  always_comb begin
    pp       = {{WIDTH{1'b0}}, mag_a_q} * {{(2*WIDTH-STEP){1'b0}}, mag_b_q[STEP-1:0]};
    shamt    = ShW'(idx_q) * ShW'(STEP);
    pp_shift = pp << shamt;
    acc_next = acc_q + pp_shift;
  end

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct magnitude.
          mag_a_d = neg_a ? -bus.a : bus.a;
          mag_b_d = neg_b ? -bus.b : bus.b;
          neg_d   = neg_a ^ neg_b;
          acc_d   = '0;
          cnt_d   = CntW'(N);
          idx_d   = '0;
          if ((bus.a == '0) || (bus.b == '0)) begin
            product_d = '0;
            state_d   = StDone;
          end else begin
            state_d   = StCalc;
          end
        end
      end

      StCalc: begin
        acc_d   = acc_next;
        mag_b_d = mag_b_q >> STEP;
        idx_d   = idx_q + IdxW'(1);
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          product_d = neg_q ? -acc_next : acc_next;
          state_d   = StDone;
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      product_q <= product_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier (WIDTH=16, STEP=2).
// A protocol/arithmetic model advanced on each rising edge predicts in_ready, busy,
// out_valid and product; a compare process checks them on every falling edge. Directed
// transactions also pin results and latencies to hand-computed literals.
module tb_iter_multiplier;

  localparam int unsigned W = 16;
  localparam int unsigned S = 2;
  localparam int unsigned N = W / S;

  logic clk = 1'b0;
  logic rst;

  int vectors = 0;
  int miscompares = 0;

  iter_multiplier_if #(.WIDTH(W)) bus ();

  iter_multiplier #(
    .WIDTH(W),
    .STEP (S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact product of the operands as integers, wrapped to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sx, input logic sy);
    longint xv, yv, p;
    if (sx) xv = longint'($signed(x));
    else    xv = longint'(x);
    if (sy) yv = longint'($signed(y));
    else    yv = longint'(y);
    p = xv * yv;
    return (2*W)'(p);
  endfunction

  // Model: phase 0 idle, 1 computing (mdl_left cycles to go), 2 holding the result.
  int               mdl_phase = 0;
  int               mdl_left  = 0;
  logic [2*W-1:0]   mdl_prod  = '0;
  logic [2*W-1:0]   mdl_pend  = '0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_phase <= 0;
      mdl_left  <= 0;
      mdl_prod  <= '0;
    end else begin
      case (mdl_phase)
        0: if (bus.in_valid) begin
          if (bus.a == '0 || bus.b == '0) begin
            mdl_phase <= 2;
            mdl_prod  <= '0;
          end else begin
            mdl_phase <= 1;
            mdl_left  <= N;
            mdl_pend  <= ref_mul(bus.a, bus.b, bus.signed_a, bus.signed_b);
          end
        end
        1: begin
          if (mdl_left == 1) begin
            mdl_phase <= 2;
            mdl_prod  <= mdl_pend;
          end else begin
            mdl_left <= mdl_left - 1;
          end
        end
        default: if (bus.out_ready) mdl_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(bus.in_ready), 64'(mdl_phase == 0));
    chk("busy", 64'(bus.busy), 64'(mdl_phase != 0));
    chk("out_valid", 64'(bus.out_valid), 64'(mdl_phase == 2));
    chk("product", 64'(bus.product), 64'(mdl_prod));
  end

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.in_ready) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("idle_wait", 64'(seen), 64'(1));
  endtask

  // Runs one transaction starting 1 time unit after a rising edge. exp_lat is the number
  // of rising edges after the accepting edge before out_valid is seen (N on the normal
  // path; 0 on the zero fast path, which completes on the accepting edge itself).
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic sa,
                       input logic sb, input int stall, input logic [2*W-1:0] exp_p,
                       input int exp_lat);
    int lat = 0;
    bit seen = 0;
    wait_idle();
    bus.in_valid  = 1'b1;
    bus.a         = ta;
    bus.b         = tb2;
    bus.signed_a  = sa;
    bus.signed_b  = sb;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4 * N && !seen; i++) begin
      if (bus.out_valid) seen = 1;
      else begin
        // Noise on the operand side while busy must be ignored.
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", 64'(bus.product), 64'(exp_p));
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(posedge clk);
      #1;
      chk("stall_product", 64'(bus.product), 64'(exp_p));
      chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("ready_after_take", 64'(bus.in_ready), 64'(1));
    chk("product_kept", 64'(bus.product), 64'(exp_p));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rsa, rsb;
    int           pick;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.signed_a  = 1'b0;
    bus.signed_b  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_product", 64'(bus.product), 64'(0));
    rst = 1'b0;

    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, 32'hFFFE0001, N);
    do_op(16'hFFFD, 16'h0005, 1'b1, 1'b1, 0, 32'hFFFFFFF1, N);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b1, 0, 32'h40000000, N);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 32'hFFFF0001, N);
    do_op(16'h0000, 16'h1234, 1'b0, 1'b0, 0, 32'h00000000, 0);
    do_op(16'h1234, 16'h0000, 1'b1, 1'b1, 2, 32'h00000000, 0);
    // Backpressure with new operands offered while the result is held.
    do_op(16'h0003, 16'hFFFC, 1'b0, 1'b1, 5, 32'hFFFFFFF4, N);

    // Reset in the 4th computing cycle discards the operation and clears the product.
    wait_idle();
    bus.in_valid = 1'b1;
    bus.a        = 16'h1234;
    bus.b        = 16'h0567;
    bus.signed_a = 1'b0;
    bus.signed_b = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("calc_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("midrst_product", 64'(bus.product), 64'(0));
    do_op(16'h0003, 16'h0007, 1'b0, 1'b0, 0, 32'h00000015, N);

    for (int k = 0; k < 200; k++) begin
      pick = int'($urandom_range(0, 9));
      ra   = W'($urandom);
      rb   = W'($urandom);
      if (pick == 0) ra = '0;
      if (pick == 1) rb = '0;
      if (pick == 2) ra = 16'h8000;
      if (pick == 3) rb = 16'hFFFF;
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      do_op(ra, rb, rsa, rsb, int'($urandom_range(0, 3)), ref_mul(ra, rb, rsa, rsb),
            (ra == '0 || rb == '0) ? 0 : N);
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
